pb_opcode_latch: RTL and testbench
==================================

Name: pb_opcode_latch

Overview:
- Input-conditioning stage directly upstream of the ALU.
- Takes raw board push switches and DIP switches, synchronises and debounces the push switches, and detects press edges.
- On each press, latches a stable one-hot opcode and a snapshot of the DIP operand for the ALU.
- The ALU then sees glitch-free, held values instead of live mechanical inputs.

Parameters:
- N_BTN, 6, number of push switches; also the opcode width.
- OPERAND_W, 10, DIP operand width.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles required to accept a level change; must be ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- push_switch  input  N_BTN  raw push switches; 1 = pressed; bit 0 = switch1
- dip_switch  input  OPERAND_W  raw DIP switches
- opcode  output  N_BTN  latched one-hot opcode to the ALU; 0 = none
- operand  output  OPERAND_W  operand captured at the last press
- opcode_valid  output  1  one-cycle pulse on the edge opcode/operand are loaded
- btn_level  output  N_BTN  debounced level of each switch

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (asserted asynchronously):
  - opcode, operand, opcode_valid, btn_level: all 0.
  - Synchroniser flops and debounce counters: 0.
- Synchronisation: each push_switch and dip_switch bit passes through a 2-flop synchroniser (s1→s2).
- Debounce, per button i, with counter width $clog2(DEBOUNCE_CYCLES):
  - If s2[i]==btn_level[i]: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: btn_level[i] <= s2[i], counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the old level before acceptance clears the counter; no partial credit.
- Latency: raw level first sampled at edge 1 → btn_level changes at edge DEBOUNCE_CYCLES+2, provided it stays stable.
- Press event for button i: the counter reaches terminal count with s2[i]=1 and btn_level[i]=0, i.e. the same edge btn_level[i] rises.
- On that same edge:
  - opcode <= one-hot(i).
  - operand <= synchronised dip_switch (dip s2).
  - opcode_valid <= 1.
- opcode_valid is 0 on every other edge and never stays high for 2 cycles unless press events occur on consecutive edges.
- Simultaneous press events on one edge: lowest index wins. Others still update btn_level but generate no load.
- Release events only update btn_level. opcode and operand are held indefinitely.
- A press of a different button while another is held: loads normally; the newest press wins.
- Re-pressing the same button: reloads the same opcode, re-captures the operand, pulses opcode_valid.
- DIP changes between presses: no effect on operand.
- Reset mid-debounce: counters clear; the count restarts after release of rst_n. A held button after reset produces a press event DEBOUNCE_CYCLES+2 edges later.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: OPCODE_TOGGLE_EN.
- Defined: a press event whose winning index equals the currently latched one-hot opcode clears opcode to 0. operand is still re-captured and opcode_valid still pulses. A press of any other button loads its one-hot.
- Undefined: every press event loads one-hot(i) as described in Behaviour.

Test Plan:
- DEBOUNCE_CYCLES=4, dip=10'h2A5, push_switch[2] 0→1 held → opcode=6'b000100, operand=10'h2A5, opcode_valid pulses for exactly 1 cycle on edge 6; btn_level[2]=1.
- DEBOUNCE_CYCLES=4, push_switch[0] toggles 1,1,0,1,1,1,0 (bounce) then stable 1 → no load during bounce; single load to 6'b000001 only after 4 stable synchronised cycles.
- push_switch[5] and push_switch[1] rise same cycle → opcode=6'b000010, one valid pulse; btn_level=6'b100010.
- Press btn3 with dip=10'h001, release, change dip to 10'h3FF, wait → operand stays 10'h001. Press btn4 → opcode=6'b010000, operand=10'h3FF.
- rst_n low for 1 cycle mid-count with push_switch[1] held → all outputs 0 immediately. Load occurs DEBOUNCE_CYCLES+2 edges after rst_n rises.
- OPCODE_TOGGLE_EN defined: press btn2 twice → opcode 6'b000100 then 6'b000000, two valid pulses. Macro undefined: second press keeps 6'b000100.

Source files
------------

// File: rtl/pb_opcode_latch_if.sv
// Switch-to-ALU bundle: raw board switches in, latched opcode/operand and debounced levels out.
interface pb_opcode_latch_if #(
    parameter int unsigned N_BTN     = 6,
    parameter int unsigned OPERAND_W = 10
);
    logic [N_BTN-1:0]     push_switch;
    logic [OPERAND_W-1:0] dip_switch;
    logic [N_BTN-1:0]     opcode;
    logic [OPERAND_W-1:0] operand;
    logic                 opcode_valid;
    logic [N_BTN-1:0]     btn_level;

    // Board side drives the switches and observes the latched results.
    modport master (
        output push_switch, dip_switch,
        input  opcode, operand, opcode_valid, btn_level
    );

    // The conditioning stage itself.
    modport slave (
        input  push_switch, dip_switch,
        output opcode, operand, opcode_valid, btn_level
    );
endinterface

// File: rtl/pb_opcode_latch.sv
// Synchronise/debounce push switches and latch a one-hot opcode plus DIP operand on each press.
// Optional build macro OPCODE_TOGGLE_EN: re-pressing the latched opcode's button clears it.
module pb_opcode_latch #(
    parameter int unsigned N_BTN           = 6,
    parameter int unsigned OPERAND_W       = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input logic               clk,
    input logic               rst_n,
    pb_opcode_latch_if.slave  bus
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]            push_s1_q, push_s1_d, push_s2_q, push_s2_d;
    logic [OPERAND_W-1:0]        dip_s1_q, dip_s1_d, dip_s2_q, dip_s2_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]            btn_level_q, btn_level_d;
    logic [N_BTN-1:0]            opcode_q, opcode_d;
    logic [OPERAND_W-1:0]        operand_q, operand_d;
    logic                        opcode_valid_q, opcode_valid_d;
    logic [N_BTN-1:0]            press;
    logic [N_BTN-1:0]            win;

    // Synchronisers, per-button debounce counters and the opcode/operand latch.
    always_comb begin
        push_s1_d      = bus.push_switch;
        push_s2_d      = push_s1_q;
        dip_s1_d       = bus.dip_switch;
        dip_s2_d       = dip_s1_q;
        cnt_d          = cnt_q;
        btn_level_d    = btn_level_q;
        opcode_d       = opcode_q;
        operand_d      = operand_q;
        opcode_valid_d = 1'b0;
        press          = '0;
        win            = '0;

        for (int i = 0; i < int'(N_BTN); i++) begin
            if (push_s2_q[i] == btn_level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                btn_level_d[i] = push_s2_q[i];
                cnt_d[i]       = '0;
                press[i]       = push_s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Isolate the lowest set bit so the lowest-index press wins.
        win = press & (~press + N_BTN'(1));

        if (|press) begin
            opcode_valid_d = 1'b1;
            operand_d      = dip_s2_q;
`ifdef OPCODE_TOGGLE_EN
            opcode_d       = (win == opcode_q) ? '0 : win;
`else
            opcode_d       = win;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_s1_q      <= '0;
            push_s2_q      <= '0;
            dip_s1_q       <= '0;
            dip_s2_q       <= '0;
            cnt_q          <= '0;
            btn_level_q    <= '0;
            opcode_q       <= '0;
            operand_q      <= '0;
            opcode_valid_q <= 1'b0;
        end else begin
            push_s1_q      <= push_s1_d;
            push_s2_q      <= push_s2_d;
            dip_s1_q       <= dip_s1_d;
            dip_s2_q       <= dip_s2_d;
            cnt_q          <= cnt_d;
            btn_level_q    <= btn_level_d;
            opcode_q       <= opcode_d;
            operand_q      <= operand_d;
            opcode_valid_q <= opcode_valid_d;
        end
    end

    assign bus.opcode       = opcode_q;
    assign bus.operand      = operand_q;
    assign bus.opcode_valid = opcode_valid_q;
    assign bus.btn_level    = btn_level_q;
endmodule

// File: tb/tb_pb_opcode_latch.sv
// Directed bench for pb_opcode_latch with a short debounce window (4 cycles).
module tb_pb_opcode_latch;
    localparam int unsigned N_BTN     = 6;
    localparam int unsigned OPERAND_W = 10;
    localparam int unsigned DEB       = 4;

`ifdef OPCODE_TOGGLE_EN
    localparam logic [5:0] OPC_REP4 = 6'b000000;
    localparam logic [5:0] OPC_REP2 = 6'b000000;
`else
    localparam logic [5:0] OPC_REP4 = 6'b010000;
    localparam logic [5:0] OPC_REP2 = 6'b000100;
`endif

    typedef struct {
        logic [5:0] push;
        logic [9:0] dip;
        int         n;
        logic [5:0] opc;
        logic [9:0] opd;
        logic       vld;
        logic [5:0] lvl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pb_opcode_latch_if #(.N_BTN(N_BTN), .OPERAND_W(OPERAND_W)) bus ();

    pb_opcode_latch #(
        .N_BTN(N_BTN), .OPERAND_W(OPERAND_W), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [5:0] push, logic [9:0] dip, int n,
                                logic [5:0] opc, logic [9:0] opd, logic vld, logic [5:0] lvl);
        vec_t v;
        v.push = push; v.dip = dip; v.n = n;
        v.opc = opc; v.opd = opd; v.vld = vld; v.lvl = lvl;
        return v;
    endfunction

    task automatic chk_all(input string tag, input logic [5:0] opc, input logic [9:0] opd,
                           input logic vld, input logic [5:0] lvl);
        chk({tag, ".opcode"},       32'(bus.opcode),       32'(opc));
        chk({tag, ".operand"},      32'(bus.operand),      32'(opd));
        chk({tag, ".opcode_valid"}, 32'(bus.opcode_valid), 32'(vld));
        chk({tag, ".btn_level"},    32'(bus.btn_level),    32'(lvl));
    endtask

    initial begin
        vec_t vecs[$];
        logic [5:0] bounce [7];

        // Each record: apply push/dip, advance n edges, then expect the outputs.
        vecs.push_back(mk(6'b000100, 10'h2A5,  5, 6'h00, 10'h000, 1'b0, 6'h00));
        vecs.push_back(mk(6'b000100, 10'h2A5,  1, 6'h04, 10'h2A5, 1'b1, 6'h04));
        vecs.push_back(mk(6'b000100, 10'h2A5,  1, 6'h04, 10'h2A5, 1'b0, 6'h04));
        vecs.push_back(mk(6'b000000, 10'h2A5,  5, 6'h04, 10'h2A5, 1'b0, 6'h04));
        vecs.push_back(mk(6'b000000, 10'h2A5,  1, 6'h04, 10'h2A5, 1'b0, 6'h00));
        vecs.push_back(mk(6'b000000, 10'h3FF, 10, 6'h04, 10'h2A5, 1'b0, 6'h00));
        vecs.push_back(mk(6'b100010, 10'h3FF,  5, 6'h04, 10'h2A5, 1'b0, 6'h00));
        vecs.push_back(mk(6'b100010, 10'h3FF,  1, 6'h02, 10'h3FF, 1'b1, 6'h22));
        vecs.push_back(mk(6'b100010, 10'h3FF,  1, 6'h02, 10'h3FF, 1'b0, 6'h22));
        vecs.push_back(mk(6'b101010, 10'h001,  6, 6'h08, 10'h001, 1'b1, 6'h2A));
        vecs.push_back(mk(6'b101010, 10'h001,  1, 6'h08, 10'h001, 1'b0, 6'h2A));
        vecs.push_back(mk(6'b000000, 10'h001,  6, 6'h08, 10'h001, 1'b0, 6'h00));
        vecs.push_back(mk(6'b000000, 10'h3FF,  8, 6'h08, 10'h001, 1'b0, 6'h00));
        vecs.push_back(mk(6'b010000, 10'h3FF,  6, 6'h10, 10'h3FF, 1'b1, 6'h10));
        vecs.push_back(mk(6'b000000, 10'h3FF,  6, 6'h10, 10'h3FF, 1'b0, 6'h00));
        vecs.push_back(mk(6'b010000, 10'h155,  6, OPC_REP4, 10'h155, 1'b1, 6'h10));
        vecs.push_back(mk(6'b010000, 10'h155,  1, OPC_REP4, 10'h155, 1'b0, 6'h10));
        vecs.push_back(mk(6'b000000, 10'h155,  6, OPC_REP4, 10'h155, 1'b0, 6'h00));
        vecs.push_back(mk(6'b000100, 10'h0AA,  6, 6'h04, 10'h0AA, 1'b1, 6'h04));
        vecs.push_back(mk(6'b000000, 10'h0AA,  6, 6'h04, 10'h0AA, 1'b0, 6'h00));
        vecs.push_back(mk(6'b000100, 10'h0BB,  6, OPC_REP2, 10'h0BB, 1'b1, 6'h04));
        vecs.push_back(mk(6'b000000, 10'h0BB,  6, OPC_REP2, 10'h0BB, 1'b0, 6'h00));

        rst_n           = 1'b0;
        bus.push_switch = '0;
        bus.dip_switch  = '0;
        step(3);
        chk_all("reset", 6'h00, 10'h000, 1'b0, 6'h00);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            bus.push_switch = vecs[k].push;
            bus.dip_switch  = vecs[k].dip;
            step(vecs[k].n);
            chk_all($sformatf("vec%0d", k), vecs[k].opc, vecs[k].opd, vecs[k].vld, vecs[k].lvl);
        end

        // Bounce on btn0: longest run of 1s is 3 cycles, so no load may occur.
        bounce = '{6'h01, 6'h01, 6'h00, 6'h01, 6'h01, 6'h01, 6'h00};
        for (int b = 0; b < 7; b++) begin
            bus.push_switch = bounce[b];
            step(1);
            chk($sformatf("bounce%0d.valid", b), 32'(bus.opcode_valid), 32'd0);
        end
        bus.push_switch = 6'h01;
        for (int b = 0; b < 5; b++) begin
            step(1);
            chk($sformatf("settle%0d.valid", b), 32'(bus.opcode_valid), 32'd0);
        end
        step(1);
        chk_all("bounce_load", 6'h01, 10'h0BB, 1'b1, 6'h01);
        step(1);
        chk("bounce_after.valid", 32'(bus.opcode_valid), 32'd0);

        // Reset mid-count with btn1 held; outputs clear at once, count restarts.
        bus.push_switch = 6'h02;
        bus.dip_switch  = 10'h2A5;
        step(3);
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 6'h00, 10'h000, 1'b0, 6'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int b = 0; b < 5; b++) begin
            step(1);
            chk($sformatf("post_reset%0d.valid", b), 32'(bus.opcode_valid), 32'd0);
        end
        step(1);
        chk_all("post_reset_load", 6'h02, 10'h2A5, 1'b1, 6'h02);
        step(1);
        chk("post_reset_after.valid", 32'(bus.opcode_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
